// File: rtl/jt49_avg.sv
`default_nettype none
// ============================================================================
//  Module   : jt49_avg
//  Purpose  : Boxcar (moving-average) low-pass stage for the JT49 audio
//             filter chain. Keeps the last 2^depth samples in a RAM delay
//             line. Maintains a running window sum and outputs sum/2^depth.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   1           system clock
//    rst_n  in   1           synchronous active-low reset
//    cen    in   1           sample strobe, one sample per high cycle
//    din    in   dw          unsigned input sample
//    dout   out  dw          registered truncated window mean
//    sum    out  dw+depth    registered running window sum
//    full   out  1           high once 2^depth samples accepted since reset
// ============================================================================
module jt49_avg #(
  parameter int dw    = 8,
  parameter int depth = 4   // must be >= 1 so the write and read addresses differ
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cen,
  input  logic [dw-1:0]         din,
  output logic [dw-1:0]         dout,
  output logic [dw+depth-1:0]   sum,
  output logic                  full
);

  localparam int               C_N      = 1 << depth;
  localparam int               C_SW     = dw + depth;
  localparam logic [depth:0]   C_CNT_N  = C_N[depth:0];
  localparam logic [depth:0]   C_CNT_1  = {{depth{1'b0}}, 1'b1};
  localparam logic [depth-1:0] C_WP_1   = {{(depth-1){1'b0}}, 1'b1};

  // Delay line; no reset so it maps onto block RAM.
  logic [dw-1:0]    ram_q [C_N];

  logic [depth-1:0] wp_q,   wp_d;
  logic [depth:0]   cnt_q,  cnt_d;
  logic [dw-1:0]    rq_q;
  logic [C_SW-1:0]  sum_q,  sum_d;
  logic [dw-1:0]    dout_q, dout_d;
  logic             full_q, full_d;
  logic [dw-1:0]    w_old;

  always_comb begin
    wp_d   = wp_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    dout_d = dout_q;
    full_d = full_q;
    // Until the window has been filled once, RAM may hold pre-reset data,
    // so nothing is removed from the sum.
    w_old  = full_q ? rq_q : '0;
    if (cen) begin
      wp_d   = wp_q + C_WP_1;
      sum_d  = sum_q + {{depth{1'b0}}, din} - {{depth{1'b0}}, w_old};
      dout_d = sum_d[C_SW-1:depth];
      cnt_d  = (cnt_q == C_CNT_N) ? cnt_q : cnt_q + C_CNT_1;
      full_d = (cnt_d == C_CNT_N);
    end
  end

  // RAM write port: the newest sample lands at wp.
  always_ff @(posedge clk) begin
    if (rst_n && cen) begin
      ram_q[wp_q] <= din;
    end
  end

  // Synchronous read one slot ahead of the write: rq holds ram[wp] whenever
  // the next strobe arrives, which is the sample leaving the window. The read
  // address is wp_d (never equal to the current write address wp while cen).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rq_q <= '0;
    end else begin
      rq_q <= ram_q[wp_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q   <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
      dout_q <= '0;
      full_q <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      dout_q <= dout_d;
      full_q <= full_d;
    end
  end

  assign dout = dout_q;
  assign sum  = sum_q;
  assign full = full_q;

endmodule
`default_nettype wire

// File: tb/tb_jt49_avg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jt49_avg
//  Purpose  : Directed self-checking bench for jt49_avg (dw=8, depth=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jt49_avg;

  localparam int DW    = 8;
  localparam int DEPTH = 2;

  logic              clk;
  logic              rst_n;
  logic              cen;
  logic [DW-1:0]     din;
  logic [DW-1:0]     dout;
  logic [DW+DEPTH-1:0] sum;
  logic              full;

  int n_vec;
  int n_err;

  logic [7:0] smp [12];
  int         hist [$];

  jt49_avg #(.dw(DW), .depth(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .din   (din),
    .dout  (dout),
    .sum   (sum),
    .full  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int e_dout, input int e_sum, input int e_full);
    chk({tag, ".dout"}, 32'(dout), e_dout);
    chk({tag, ".sum"},  32'(sum),  e_sum);
    chk({tag, ".full"}, 32'(full), e_full);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cen = 1'b0; din = '0;
    tick();
    rst_n = 1'b1;
    hist.delete();
  endtask

  task automatic strobe(input logic [7:0] d);
    cen = 1'b1; din = d;
    tick();
    cen = 1'b0;
    hist.push_back(int'(d));
  endtask

  // Reference: plain sum of the last four samples seen since reset.
  function automatic int win_sum();
    int s = 0;
    int n = hist.size();
    for (int i = (n > 4 ? n - 4 : 0); i < n; i++) s += hist[i];
    return s;
  endfunction

  initial begin
    n_vec = 0; n_err = 0;
    smp = '{8'h3C, 8'hF1, 8'h07, 8'h9A, 8'h55, 8'hE0,
            8'h12, 8'hC8, 8'h6B, 8'h01, 8'hFE, 8'h80};
    rst_n = 1'b0; cen = 1'b0; din = 8'h55;

    // ---- Reset with cen toggling --------------------------------------
    cen = 1'b1; tick(); chk3("rst0", 0, 0, 0);
    cen = 1'b0; tick(); chk3("rst1", 0, 0, 0);
    rst_n = 1'b1; tick(); chk3("rst_rel", 0, 0, 0);

    // ---- Step response ------------------------------------------------
    for (int k = 1; k <= 4; k++) begin
      cen = 1'b1; din = 8'h80; tick();
      chk3($sformatf("step_up%0d", k), 32 * k, 128 * k, (k == 4) ? 1 : 0);
    end
    for (int k = 1; k <= 4; k++) begin
      cen = 1'b1; din = 8'h00; tick();
      chk3($sformatf("step_dn%0d", k), 128 - 32 * k, 512 - 128 * k, 1);
    end
    cen = 1'b0;

    // ---- Dense cen ----------------------------------------------------
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cen = 1'b1; din = smp[k]; tick();
      hist.push_back(int'(smp[k]));
      chk3($sformatf("dense%0d", k), win_sum() / 4, win_sum(), (k >= 3) ? 1 : 0);
    end
    cen = 1'b0;

    // ---- Sparse cen (every third cycle), outputs hold between ---------
    do_reset();
    for (int k = 0; k < 12; k++) begin
      strobe(smp[k]);
      chk3($sformatf("sparse%0d", k), win_sum() / 4, win_sum(), (k >= 3) ? 1 : 0);
      din = ~smp[k];
      tick(); tick();
      chk3($sformatf("hold%0d", k), win_sum() / 4, win_sum(), (k >= 3) ? 1 : 0);
    end

    // ---- Saturation and pointer wrap ----------------------------------
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cen = 1'b1; din = 8'hFF; tick();
      if (k >= 4) chk3($sformatf("sat%0d", k), 255, 1020, 1);
    end
    cen = 1'b0;

    // ---- Reset mid-run ------------------------------------------------
    do_reset();
    for (int k = 0; k < 6; k++) strobe(8'hFF);
    chk3("midrun_pre", 255, 1020, 1);
    do_reset();
    chk3("midrun_rst", 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      strobe(8'h10);
      chk3($sformatf("midrun%0d", k), (k > 4 ? 4 : k) * 4, (k > 4 ? 4 : k) * 16, (k >= 4) ? 1 : 0);
    end

    // ---- Reset and cen in the same cycle ------------------------------
    rst_n = 1'b0; cen = 1'b1; din = 8'hAA; tick();
    chk3("coll_rst", 0, 0, 0);
    rst_n = 1'b1; cen = 1'b1; din = 8'h40; tick();
    cen = 1'b0;
    chk3("coll_first", 16, 64, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jt49_avg.md
Name: jt49_avg

Overview:
- Boxcar (moving-average) low-pass stage for the JT49 audio filter chain.
- Consumes a stream of unsigned samples qualified by cen.
- Keeps the last 2^depth samples in an internal RAM delay line, on the read side.
- Maintains a running sum (add newest, subtract the one falling out of the window) and outputs sum / 2^depth.

Parameters:
- dw, 8, sample width in bits (input and output).
- depth, 4, log2 of window length; window N = 2^depth samples.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- cen  input  1  sample strobe; one new sample per high cycle; may be high on consecutive cycles.
- din  input  dw  unsigned input sample, valid when cen=1.
- dout  output  dw  averaged sample, registered.
- sum  output  dw+depth  running window sum, registered.
- full  output  1  high once N samples have been accepted since reset.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at posedge):
  - dout=0, sum=0, full=0.
  - Write pointer wp=0, fill counter=0, read-ahead register rq=0.
  - RAM contents are not cleared.
- Storage:
  - RAM of N x dw, single write port, synchronous read port.
  - Must map to block RAM.
- Read-ahead, every clk when not in reset:
  - rq <= ram[wp_next], where wp_next = cen ? wp+1 : wp (modulo N).
  - rq therefore always holds ram[wp] at any cen cycle, including back-to-back cen.
- Read/write collision: the write targets wp and the read targets wp+1, so they never collide. Requirement for depth>=1: N>=2.
- Oldest sample: old = full ? rq : 0.
  - Stale RAM from before a reset is never subtracted.
- On cen=1:
  - ram[wp] <= din.
  - wp <= wp+1, wrapping from N-1 to 0.
  - sum <= sum + din - old, computed at width dw+depth. The result is never negative and never overflows, since old is already contained in sum and the maximum is N*(2^dw-1).
  - dout <= (sum + din - old) >> depth, i.e. the truncated mean including the current sample.
  - Fill counter increments, saturating at N; full <= 1 when the counter reaches N.
- Latency: dout and sum reflect the sample accepted at cen edge k from edge k onward, visible in the cycle after that edge.
- cen=0: all outputs and state hold; only rq refreshes.
- Warm-up: during the first N samples, dout = (partial sum)/N, i.e. a ramp from 0. No special scaling.
- Reset mid-operation: the next sample after reset release starts a fresh window. RAM garbage is excluded by the full gating.
- rst_n=0 and cen=1 in the same cycle: reset wins and the sample is dropped.

Test Plan:
- Reset: rst_n=0 for 2 clk with cen toggling -> dout=0, sum=0, full=0 throughout and on the first cycle after release.
- Step response (dw=8, depth=2, N=4): four cen with din=8'h80, back-to-back -> dout 32,64,96,128; sum 128,256,384,512; full rises with the 4th sample. Then four cen with din=0 -> dout 96,64,32,0; full stays 1.
- Sparse vs dense cen: the same 12-sample random sequence applied with cen every cycle and with cen every 3rd cycle -> identical dout/sum sequences, both matching a reference model floor(sum of last 4)/4. Outputs stable between strobes.
- Saturation and wrap (depth=2): 20 samples of 8'hFF -> sum settles at 1020, dout=255. No overflow across multiple wp wraps.
- Reset mid-run (depth=2): load 8'hFF for 6 samples, pulse rst_n=0 one cycle, then feed 8'h10 four times -> dout 4,8,12,16; sum 16,32,48,64. Old 8'hFF contents never subtracted.
- Reset/cen collision: rst_n=0 with cen=1 and din=8'hAA -> sample discarded. The next post-reset sample 8'h40 yields sum=64, dout=16 (depth=2).
